// File: rtl/k12a_spi_slave_pkg.sv
// K12a SPI target: shared types, IO map and helpers.
// Imported by the SPI target RTL and its bench.
package k12a_spi_slave_pkg;

    typedef enum logic {
        SPI_SLAVE_STATE_IDLE = 1'b0,
        SPI_SLAVE_STATE_XFER = 1'b1
    } spi_slave_state_t;

    localparam logic [7:0] IO_SPI_SLAVE_TX     = 8'h18;
    localparam logic [7:0] IO_SPI_SLAVE_RX     = 8'h19;
    localparam logic [7:0] IO_SPI_SLAVE_STATUS = 8'h1A;

    // Byte to present on MISO: the pending TX byte or the idle filler.
    function automatic logic [7:0] spi_slave_tx_pick(
        input logic       empty,
        input logic [7:0] tx_val,
        input logic [7:0] idle_val
    );
        return empty ? idle_val : tx_val;
    endfunction

endpackage

// File: rtl/k12a_spi_slave_if.sv
// K12a SPI target: IO-bus strobes, status and SPI pins.
// slave = the peripheral, master = CPU plus external SPI master.
interface k12a_spi_slave_if;

    logic       spi_slave_tx_store;
    logic       spi_slave_rx_load;
    logic [7:0] data_in;
    logic [7:0] rx_data;
    logic       rx_full;
    logic       tx_empty;
    logic       overrun;
    logic       busy;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_ss_n;
    logic       spi_miso;
    logic       spi_miso_oe;

    modport slave (
        input  spi_slave_tx_store, spi_slave_rx_load, data_in,
        input  spi_sck, spi_mosi, spi_ss_n,
        output rx_data, rx_full, tx_empty, overrun, busy,
        output spi_miso, spi_miso_oe
    );

    modport master (
        output spi_slave_tx_store, spi_slave_rx_load, data_in,
        output spi_sck, spi_mosi, spi_ss_n,
        input  rx_data, rx_full, tx_empty, overrun, busy,
        input  spi_miso, spi_miso_oe
    );

endinterface

// File: rtl/k12a_spi_slave_sync.sv
// K12a SPI target: input synchroniser with edge pulses.
// Pulses come from the last synchronised stage versus its previous value.
module k12a_spi_slave_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign dout = chain[STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/k12a_spi_slave.sv
// K12a SPI target: mode-0 byte exchange with an external SPI master.
// MSB-first, oversampled in the CPU clock domain.
module k12a_spi_slave
    import k12a_spi_slave_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] IDLE_TX_BYTE = 8'hFF
) (
    input logic              clock,
    input logic              reset,
    k12a_spi_slave_if.slave  bus
);

    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic sync_unused;

    k12a_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
        .clock(clock), .reset(reset), .din(bus.spi_sck),
        .dout(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    k12a_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
        .clock(clock), .reset(reset), .din(bus.spi_mosi),
        .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    k12a_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss (
        .clock(clock), .reset(reset), .din(bus.spi_ss_n),
        .dout(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );

    assign sync_unused = ^{sck_lvl, mosi_rise, mosi_fall, ss_lvl};

    spi_slave_state_t state_q, state_d;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_sh, rx_sh, tx_buf;
    logic             tx_empty_q, rx_full_q, overrun_q;
    logic [7:0]       rx_data_q;
    logic             tx_load, tx_shift, rx_shift, byte_done, cnt_clr;
    logic [7:0]       rx_byte, tx_next;

    assign rx_byte = {rx_sh[6:0], mosi_s};
    assign tx_next = spi_slave_tx_pick(tx_empty_q, tx_buf, IDLE_TX_BYTE);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= SPI_SLAVE_STATE_IDLE;
        else       state_q <= state_d;
    end

    // Next state and per-cycle datapath controls; SS release wins over SCK.
    always_comb begin
        state_d   = state_q;
        tx_load   = 1'b0;
        tx_shift  = 1'b0;
        rx_shift  = 1'b0;
        byte_done = 1'b0;
        cnt_clr   = 1'b0;
        case (state_q)
            SPI_SLAVE_STATE_IDLE: begin
                if (ss_fall) begin
                    state_d = SPI_SLAVE_STATE_XFER;
                    tx_load = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            SPI_SLAVE_STATE_XFER: begin
                if (ss_rise) begin
                    state_d = SPI_SLAVE_STATE_IDLE;
                    cnt_clr = 1'b1;
                end else if (sck_rise) begin
                    rx_shift  = 1'b1;
                    byte_done = (bit_cnt == 3'd7);
                end else if (sck_fall) begin
                    tx_load  = (bit_cnt == 3'd0);
                    tx_shift = (bit_cnt != 3'd0);
                end
            end
            default: state_d = SPI_SLAVE_STATE_IDLE;
        endcase
    end

    // Shift registers and bit counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt <= 3'd0;
            tx_sh   <= 8'd0;
            rx_sh   <= 8'd0;
        end else begin
            if (cnt_clr)       bit_cnt <= 3'd0;
            else if (rx_shift) bit_cnt <= bit_cnt + 3'd1;
            if (rx_shift)      rx_sh <= rx_byte;
            if (tx_load)       tx_sh <= tx_next;
            else if (tx_shift) tx_sh <= {tx_sh[6:0], 1'b0};
        end
    end

    // TX buffer: a CPU write in the same cycle as a load still lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_buf     <= 8'd0;
            tx_empty_q <= 1'b1;
        end else begin
            if (bus.spi_slave_tx_store) begin
                tx_buf     <= bus.data_in;
                tx_empty_q <= 1'b0;
            end else if (tx_load) begin
                tx_empty_q <= 1'b1;
            end
        end
    end

    // RX byte and flags; a same-cycle read frees room for the new byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_data_q <= 8'd0;
            rx_full_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (byte_done && (!rx_full_q || bus.spi_slave_rx_load)) begin
                rx_data_q <= rx_byte;
                rx_full_q <= 1'b1;
                overrun_q <= 1'b0;
            end else if (byte_done) begin
                overrun_q <= 1'b1;
            end else if (bus.spi_slave_rx_load) begin
                rx_full_q <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_full     = rx_full_q;
    assign bus.tx_empty    = tx_empty_q;
    assign bus.overrun     = overrun_q;
    assign bus.busy        = (state_q == SPI_SLAVE_STATE_XFER);
    assign bus.spi_miso_oe = bus.busy;
    assign bus.spi_miso    = tx_sh[7];

endmodule
